// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled majority-vote sampling, optional parity,
// one or two stop bits, false-start rejection and break (continuous low) handling.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 65_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BCW     = $clog2(DATA_BITS);

    localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0]  TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 r_sync1, r_sync2;
    logic [2:0]           r_state;
    logic [DW-1:0]        r_div_cnt;
    logic [TW-1:0]        r_tick_cnt;
    logic [BCW-1:0]       r_bit_cnt;
    logic                 r_samp0, r_samp1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_seen_high;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_valid;
    logic                 r_parity_err_o;
    logic                 r_frame_err_o;

    logic w_rxs, w_tick, w_mid, w_end, w_bit, w_par_exp;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_mid  = w_tick && (r_tick_cnt == TICK_MID);
    assign w_end  = w_tick && (r_tick_cnt == TICK_LAST);
    // Third sample is taken live on the deciding tick, so the vote is ready in that cycle.
    assign w_bit  = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);
    assign w_par_exp = (PARITY == 1) ? ~r_par_acc : r_par_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_state        <= S_IDLE;
            r_div_cnt      <= '0;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_samp0        <= 1'b1;
            r_samp1        <= 1'b1;
            r_shift        <= '0;
            r_par_acc      <= 1'b0;
            r_par_err      <= 1'b0;
            r_frame_err    <= 1'b0;
            r_seen_high    <= 1'b1;
            r_rx_data      <= '0;
            r_valid        <= 1'b0;
            r_parity_err_o <= 1'b0;
            r_frame_err_o  <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;

            // Holding the counters at zero in IDLE phase-aligns ticks to the start edge.
            if (r_state == S_IDLE) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
                if (r_tick_cnt == TICK_S0) r_samp0 <= w_rxs;
                if (r_tick_cnt == TICK_S1) r_samp1 <= w_rxs;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rxs) begin
                        r_seen_high <= 1'b1;
                    end else if (r_seen_high) begin
                        r_state     <= S_START;
                        r_bit_cnt   <= '0;
                        r_par_acc   <= 1'b0;
                        r_par_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_mid && w_bit) r_state <= S_IDLE;
                    else if (w_end)     r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_bit;
                    end
                    if (w_end) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_mid) r_par_err <= w_bit ^ w_par_exp;
                    if (w_end) r_state <= S_STOP;
                end
                S_STOP: begin
                    // Final stop bit completes at mid-bit so the next start edge is never missed.
                    if (w_mid && (r_bit_cnt == STOP_LAST)) begin
                        r_valid        <= 1'b1;
                        r_rx_data      <= r_shift;
                        r_parity_err_o <= r_par_err;
                        r_frame_err_o  <= r_frame_err | ~w_bit;
                        r_state        <= S_IDLE;
                        if (!w_bit) r_seen_high <= 1'b0;
                    end else begin
                        if (w_mid && !w_bit) r_frame_err <= 1'b1;
                        if (w_end) r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign valid      = r_valid;
    assign parity_err = r_parity_err_o;
    assign frame_err  = r_frame_err_o;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances at 32 clk per bit,
// covering parity, framing, glitch rejection, break, back-to-back frames and reset.
module tb_uart_rx_cfg;

    localparam int CF     = 32_000_000;
    localparam int BR     = 1_000_000;
    localparam int OS     = 16;
    localparam int BITCLK = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic valid_a, valid_b, valid_c;
    logic perr_a, perr_b, perr_c;
    logic ferr_a, ferr_b, ferr_c;
    logic busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
    logic busy_at_v_a = 1'b1;
    logic [7:0] hist_a[$];

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(data_a), .valid(valid_a),
        .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(data_b), .valid(valid_b),
        .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .OVERSAMPLE(OS)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_c), .rx_data(data_c), .valid(valid_c),
        .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_a) begin
            vcnt_a++;
            busy_at_v_a = busy_a;
            hist_a.push_back(data_a);
        end
        if (valid_b) vcnt_b++;
        if (valid_c) vcnt_c++;
    end

    task automatic drive(input int inst, input logic v);
        case (inst)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic hold_bits(input int n);
        repeat (n * BITCLK) @(negedge clk);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input logic has_par, input logic par_bit,
                              input int nstop, input logic last_stop);
        logic [8:0] d;
        d = data;
        @(negedge clk);
        drive(inst, 1'b0);
        hold_bits(1);
        for (int i = 0; i < nbits; i++) begin
            drive(inst, d[i]);
            hold_bits(1);
        end
        if (has_par) begin
            drive(inst, par_bit);
            hold_bits(1);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(inst, (s == nstop - 1) ? last_stop : 1'b1);
            hold_bits(1);
        end
        drive(inst, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {perr_a, ferr_a}); end
        checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", {busy_a, busy_b, busy_c}); end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_8n1;
        int c0;
        c0 = vcnt_a;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        hold_bits(1);
        checks++; if (vcnt_a - c0 !== 1) begin errors++; $display("FAIL 8n1_count: got %0d want 1", vcnt_a - c0); end
        checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h want a5", data_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL 8n1_flags: got %b want 00", {perr_a, ferr_a}); end
        checks++; if (busy_at_v_a !== 1'b0) begin errors++; $display("FAIL 8n1_busy_at_valid: got %b want 0", busy_at_v_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL 8n1_busy_after: got %b want 0", busy_a); end
        $display("8n1 frame a5: data=%h perr=%b ferr=%b", data_a, perr_a, ferr_a);
    endtask

    task automatic test_parity_even;
        send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
        checks++; if (data_b !== 8'h3C) begin errors++; $display("FAIL 8e1_good_data: got %h want 3c", data_b); end
        checks++; if (perr_b !== 1'b0) begin errors++; $display("FAIL 8e1_good_perr: got %b want 0", perr_b); end
        $display("8e1 frame 3c par=0: data=%h perr=%b", data_b, perr_b);
        send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1);
        checks++; if (data_b !== 8'h3C) begin errors++; $display("FAIL 8e1_bad_data: got %h want 3c", data_b); end
        checks++; if (perr_b !== 1'b1) begin errors++; $display("FAIL 8e1_bad_perr: got %b want 1", perr_b); end
        checks++; if (vcnt_b !== 2) begin errors++; $display("FAIL 8e1_count: got %0d want 2", vcnt_b); end
        $display("8e1 frame 3c par=1: data=%h perr=%b", data_b, perr_b);
    endtask

    task automatic test_7o2;
        // 0x55 in 7 bits has four ones, so the odd parity bit is 1.
        send_frame(2, 9'h055, 7, 1'b1, 1'b1, 2, 1'b1);
        checks++; if (data_c !== 7'h55) begin errors++; $display("FAIL 7o2_data: got %h want 55", data_c); end
        checks++; if ({perr_c, ferr_c} !== 2'b00) begin errors++; $display("FAIL 7o2_flags: got %b want 00", {perr_c, ferr_c}); end
        $display("7o2 frame 55: data=%h perr=%b ferr=%b", data_c, perr_c, ferr_c);
        send_frame(2, 9'h055, 7, 1'b1, 1'b1, 2, 1'b0);
        hold_bits(1);
        checks++; if (ferr_c !== 1'b1) begin errors++; $display("FAIL 7o2_stop2_ferr: got %b want 1", ferr_c); end
        checks++; if (data_c !== 7'h55) begin errors++; $display("FAIL 7o2_stop2_data: got %h want 55", data_c); end
        checks++; if (vcnt_c !== 2) begin errors++; $display("FAIL 7o2_count: got %0d want 2", vcnt_c); end
        $display("7o2 frame 55 stop2 low: data=%h ferr=%b", data_c, ferr_c);
    endtask

    task automatic test_break;
        int c0;
        c0 = vcnt_a;
        @(negedge clk);
        drive(0, 1'b0);
        hold_bits(20);
        checks++; if (vcnt_a - c0 !== 1) begin errors++; $display("FAIL break_count: got %0d want 1", vcnt_a - c0); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL break_data: got %h want 00", data_a); end
        checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", ferr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL break_busy_low_line: got %b want 0", busy_a); end
        drive(0, 1'b1);
        hold_bits(2);
        checks++; if (vcnt_a - c0 !== 1) begin errors++; $display("FAIL break_release_count: got %0d want 1", vcnt_a - c0); end
        $display("break: data=%h ferr=%b valids=%0d", data_a, ferr_a, vcnt_a - c0);
    endtask

    task automatic test_glitch;
        int c0;
        logic saw_busy;
        logic [1:0] flags0;
        logic [7:0] data0;
        c0 = vcnt_a;
        flags0 = {perr_a, ferr_a};
        data0 = data_a;
        saw_busy = 1'b0;
        @(negedge clk);
        drive(0, 1'b0);
        repeat (8) @(negedge clk);
        drive(0, 1'b1);
        for (int i = 0; i < 3 * BITCLK; i++) begin
            @(negedge clk);
            if (busy_a) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b want 1", saw_busy); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy_a); end
        checks++; if (vcnt_a !== c0) begin errors++; $display("FAIL glitch_no_valid: got %0d want %0d", vcnt_a, c0); end
        checks++; if ({perr_a, ferr_a} !== flags0) begin errors++; $display("FAIL glitch_flags: got %b want %b", {perr_a, ferr_a}, flags0); end
        checks++; if (data_a !== data0) begin errors++; $display("FAIL glitch_data: got %h want %h", data_a, data0); end
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (data_a !== 8'h12) begin errors++; $display("FAIL glitch_then_12: got %h want 12", data_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL glitch_then_12_ferr: got %b want 0", ferr_a); end
        $display("glitch then 12: data=%h ferr=%b", data_a, ferr_a);
        send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (data_a !== 8'h7E) begin errors++; $display("FAIL post_break_7e: got %h want 7e", data_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL post_break_7e_ferr: got %b want 0", ferr_a); end
        $display("frame 7e: data=%h ferr=%b", data_a, ferr_a);
    endtask

    task automatic test_back_to_back;
        int c0;
        int h;
        logic [7:0] exp_q[3];
        exp_q[0] = 8'h01; exp_q[1] = 8'h80; exp_q[2] = 8'hFF;
        c0 = vcnt_a;
        h = hist_a.size();
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            drive(0, 1'b0);
            hold_bits(1);
            for (int i = 0; i < 8; i++) begin
                drive(0, exp_q[f][i]);
                hold_bits(1);
            end
            drive(0, 1'b1);
            hold_bits(1);
        end
        hold_bits(1);
        checks++; if (vcnt_a - c0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", vcnt_a - c0); end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (hist_a.size() < h + f + 1) begin
                errors++; $display("FAIL b2b_data%0d: got none want %h", f, exp_q[f]);
            end else if (hist_a[h+f] !== exp_q[f]) begin
                errors++; $display("FAIL b2b_data%0d: got %h want %h", f, hist_a[h+f], exp_q[f]);
            end
        end
        $display("back_to_back: valids=%0d last=%h", vcnt_a - c0, data_a);
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        c0 = vcnt_a;
        @(negedge clk);
        drive(0, 1'b0);
        hold_bits(1);
        drive(0, 1'b1);
        hold_bits(3);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy_a); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b want 00", {perr_a, ferr_a}); end
        rst_n = 1'b1;
        hold_bits(12);
        checks++; if (vcnt_a !== c0) begin errors++; $display("FAIL midrst_no_valid: got %0d want %0d", vcnt_a, c0); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL midrst_data_after: got %h want 00", data_a); end
        $display("reset mid-frame: data=%h valids=%0d", data_a, vcnt_a - c0);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_even();
        test_7o2();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
